// File: rtl/vfetch.sv
// vfetch: Thumb instruction prefetch stage.
// Fetches aligned 32-bit words, splits them into little-endian halfwords,
// queues {halfword, pc} pairs and hands them to execute one per cycle.
// A redirect flushes the queue and restarts fetch. A response that is still
// in flight when the redirect arrives is swallowed by the DROP state.
module vfetch #(
    parameter int unsigned DEPTH    = 8,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        sck,
    input  logic        rst_n,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        cmd_valid,
    output logic [15:0] cmd,
    output logic [31:0] cmd_pc,
    input  logic        cmd_ready
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam logic [31:0] RESET_FETCH = {RESET_PC[31:2], 2'b00};

    typedef struct packed {
        logic [15:0] hw;
        logic [31:0] pc;
    } entry_t;

    typedef enum logic {
        RUN  = 1'b0,
        DROP = 1'b1
    } state_t;

    entry_t        fifo [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] wr_ptr_inc;
    logic [CW-1:0] count;
    logic [CW-1:0] count_nxt;
    logic [CW-1:0] free_nxt;

    state_t        state;
    state_t        state_nxt;
    logic [31:0]   fetch_addr;
    logic [31:0]   fetch_addr_nxt;
    logic          skip_low;
    logic          skip_low_nxt;
    logic          mem_req_nxt;
    logic [31:0]   mem_addr_nxt;

    logic          ack;
    logic          pop;
    logic [1:0]    push_n;

    // bit 0 of the redirect target is meaningless for halfword-aligned code
    logic          unused_ok;
    assign unused_ok = redirect_pc[0];

    // an ack only counts while a request is actually on the bus
    assign ack        = mem_req & mem_ack;
    // a redirect empties the queue, so the same-cycle pop needs no pointer move
    assign pop        = cmd_valid & cmd_ready & ~redirect;
    assign wr_ptr_inc = wr_ptr + AW'(1);

    // next-state, fetch bookkeeping and request issue
    always_comb begin
        state_nxt      = state;
        fetch_addr_nxt = fetch_addr;
        skip_low_nxt   = skip_low;
        mem_req_nxt    = mem_req;
        mem_addr_nxt   = mem_addr;
        push_n         = 2'd0;
        count_nxt      = count;
        free_nxt       = '0;

        if (redirect) begin
            fetch_addr_nxt = {redirect_pc[31:2], 2'b00};
            skip_low_nxt   = redirect_pc[1];
            // a request still waiting for its ack must run to completion
            // on the bus; its data is thrown away later
            if (mem_req && !mem_ack) begin
                state_nxt = DROP;
            end else begin
                state_nxt = RUN;
            end
        end else if (ack) begin
            if (state == RUN) begin
                push_n         = skip_low ? 2'd1 : 2'd2;
                skip_low_nxt   = 1'b0;
                fetch_addr_nxt = fetch_addr + 32'd4;
            end
            // DROP: the stale word is discarded and fetch_addr already
            // holds the redirect target
            state_nxt = RUN;
        end

        if (redirect) begin
            count_nxt = '0;
        end else begin
            count_nxt = count + CW'(push_n) - CW'(pop);
        end
        free_nxt = CW'(DEPTH) - count_nxt;

        // issue only when the bus is free after this cycle; two free slots
        // guarantee the returning word always fits
        if (!mem_req || ack) begin
            mem_req_nxt  = (free_nxt >= CW'(2));
            mem_addr_nxt = fetch_addr_nxt;
        end
    end

    // state, fetch pointer, bus request and queue occupancy
    always_ff @(posedge sck or negedge rst_n) begin
        if (!rst_n) begin
            state      <= RUN;
            fetch_addr <= RESET_FETCH;
            skip_low   <= RESET_PC[1];
            mem_req    <= 1'b0;
            mem_addr   <= RESET_FETCH;
            count      <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
        end else begin
            state      <= state_nxt;
            fetch_addr <= fetch_addr_nxt;
            skip_low   <= skip_low_nxt;
            mem_req    <= mem_req_nxt;
            mem_addr   <= mem_addr_nxt;
            count      <= count_nxt;
            if (redirect) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                if (pop) begin
                    rd_ptr <= rd_ptr + AW'(1);
                end
                wr_ptr <= wr_ptr + AW'(push_n);
            end
        end
    end

    // queue storage; contents are don't-care until count covers them
    always_ff @(posedge sck) begin
        if (push_n == 2'd2) begin
            fifo[wr_ptr]     <= entry_t'({mem_rdata[15:0],  fetch_addr});
            fifo[wr_ptr_inc] <= entry_t'({mem_rdata[31:16], fetch_addr + 32'd2});
        end else if (push_n == 2'd1) begin
            fifo[wr_ptr]     <= entry_t'({mem_rdata[31:16], fetch_addr + 32'd2});
        end
    end

    // head presentation; outputs read zero while the queue is empty
    always_comb begin
        cmd_valid = (count != '0);
        cmd       = '0;
        cmd_pc    = '0;
        if (cmd_valid) begin
            cmd    = fifo[rd_ptr].hw;
            cmd_pc = fifo[rd_ptr].pc;
        end
    end

endmodule

// File: doc/vfetch.md
# vfetch

Thumb instruction prefetch stage that feeds the 16-bit `cmd` input of the vCPU execute stage. It fetches aligned 32-bit words from instruction memory, splits each into two little-endian halfwords, buffers them with their PCs in a small FIFO, and presents one halfword per cycle under a valid/ready handshake. A redirect from execute (branch or PC write) flushes the buffer and restarts fetch, discarding any response already in flight.

## Interface
- `DEPTH`, 8: FIFO capacity in halfwords; power of two, ≥ 4.
- `RESET_PC`, 32'h0000_0000: fetch start address after reset; bit 0 ignored, bit 1 honoured as for a redirect.

- `sck`  in  1  clock; all state changes on posedge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `redirect`  in  1  flush and restart fetch at `redirect_pc`.
- `redirect_pc`  in  32  new PC; bit 0 ignored.
- `mem_req`  out  1  fetch request; held until accepted.
- `mem_addr`  out  32  word-aligned fetch address (`[1:0]` = 0); stable while `mem_req` = 1.
- `mem_ack`  in  1  response valid; counts only when `mem_req` = 1.
- `mem_rdata`  in  32  fetched word; `[15:0]` at `mem_addr`, `[31:16]` at `mem_addr+2`.
- `cmd_valid`  out  1  `cmd` holds a valid halfword.
- `cmd`  out  16  head-of-queue instruction halfword.
- `cmd_pc`  out  32  address of `cmd` (bit 0 = 0).
- `cmd_ready`  in  1  execute consumes `cmd` this cycle.

## Operation
- FIFO entries: {halfword, pc}. `count` runs 0..DEPTH. `cmd`/`cmd_pc` show the head entry and `cmd_valid` = (`count` ≠ 0). Pop on `cmd_valid & cmd_ready`.
- Internal `fetch_addr` (word-aligned) and `skip_low` flag. At reset or redirect: `fetch_addr` = {pc[31:2], 2'b00}, `skip_low` = pc[1].
- FSM has two states:
  - RUN: `mem_req` is raised when no request is outstanding and free slots after this cycle's push/pop are ≥ 2. On an accepted ack, push `rdata[15:0]` (pc = `fetch_addr`) unless `skip_low`, then push `rdata[31:16]` (pc = `fetch_addr+2`). Clear `skip_low`. Advance `fetch_addr` by 4, wrapping modulo 2^32.
  - DROP: entered on a redirect while `mem_req` = 1 and no ack arrives in the same cycle. `mem_req`/`mem_addr` keep their old values. The next ack is discarded, with no push and no address change, and the FSM returns to RUN, fetching from the already-loaded redirect address.
- Redirect has priority over pop and push in the same cycle. The FIFO is emptied, and the head popped that cycle is considered consumed. An ack arriving in the redirect cycle is discarded, and `mem_req` then follows the normal RUN issue rule.
- A redirect during DROP reloads `fetch_addr`/`skip_low` and stays in DROP.
- Simultaneous push and pop are allowed: `count` += pushed − popped. Because issue requires ≥ 2 free slots, overflow cannot occur. A full FIFO with `cmd_ready` held low simply stalls fetch.
- Halfword classification (16- vs 32-bit Thumb) is not done here. The halfwords are delivered in order.

## Timing
- Reset values: `mem_req` = 0, `mem_addr` = {RESET_PC[31:2], 2'b00}, `cmd_valid` = 0, `cmd` = 0, `cmd_pc` = 0, `count` = 0, state RUN.
- First `mem_req` is driven high after the first posedge following reset release.
- Ack latency is unbounded; zero-wait ack (ack in the cycle `mem_req` rises) is legal.
- Ack at edge n → the pushed halfwords are visible from edge n. `cmd_valid` = 1 in cycle n+1 if the FIFO was empty.
- Back-to-back: after an ack, `mem_req` stays high for `fetch_addr+4` in the next cycle when space allows, giving one word per cycle at zero wait.
- Redirect sampled at edge k → `cmd_valid` = 0 from cycle k+1.
  - No request outstanding: new `mem_req` from cycle k+1.
  - Request outstanding: new `mem_req` in the cycle after the discarded ack.
- Sustained throughput: one halfword per cycle to execute with 1-cycle memory.

## Test plan
- Reset with RESET_PC = 0x100, memory returns 0xBBBB_AAAA at 0x100 with 1-cycle ack, `cmd_ready` = 1 → `mem_addr` 0x100; `cmd` AAAA @0x100, then BBBB @0x102, then the word at 0x104 follows with no bubble.
- Redirect to 0x202 while idle → `mem_addr` 0x200; only `rdata[31:16]` is delivered, with `cmd_pc` = 0x202; next fetch 0x204.
- Redirect to 0x300 while a request to 0x108 is pending, ack after 3 cycles → 0x108 data never appears on `cmd`; next `mem_addr` 0x300; first `cmd_pc` 0x300.
- `cmd_ready` = 0 with DEPTH = 8 → exactly 4 words fetched, `mem_req` stays low, `count` = 8, `cmd` holds the first halfword. Release `cmd_ready` → fetch resumes with no loss and no duplication.
- Redirect in the same cycle as an ack and a pop → FIFO empty next cycle, ack data discarded, no stale `cmd_valid`.
- `rst_n` asserted mid-request → all outputs return to reset values immediately (asynchronously), and fetch restarts at RESET_PC.
